mux_scan_ctrl: RTL and testbench

- Sequencer that sits directly in front of the 8:1 mux (`mux8to1`) and drives its select lines.
- On each start request it steps `sel_o` through all channels 0..7 and samples the mux output `y_i` for each one.
- It assembles the eight samples into one parallel word and presents it with a one-cycle valid pulse.
- Purpose: converts the combinational mux into a timed, handshaked scanner for downstream register-based logic.

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux8to1.sv | 11 +
 rtl/mux_scan_ctrl.sv | 102 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and state type for the 8:1 mux scanner.
// Imported by the scan controller and the bench.
package mux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/mux8to1.sv
// Combinational 8:1 multiplexer scanned by mux_scan_ctrl.
// y follows in[sel] with no registering.
module mux8to1 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = in[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through every channel, samples y_i per channel
// and publishes the assembled word with a one-cycle valid pulse.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int NUM_CH = mux_pkg::NUM_CH,
  parameter int SEL_W  = mux_pkg::SEL_W,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              y_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic [NUM_CH-1:0] data_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
  localparam logic [SEL_W-1:0] LAST     = SEL_W'(NUM_CH - 1);

  scan_state_t       state, state_n;
  logic [3:0]        wcnt, wcnt_n;
  logic [SEL_W-1:0]  sel_n;
  logic [NUM_CH-1:0] shadow, shadow_n;
  logic [NUM_CH-1:0] data_n;
  logic              valid_n;
  logic              busy_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      sel_o   <= '0;
      shadow  <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      sel_o   <= sel_n;
      shadow  <= shadow_n;
      data_o  <= data_n;
      valid_o <= valid_n;
      busy_o  <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    wcnt_n   = wcnt;
    sel_n    = sel_o;
    shadow_n = shadow;
    data_n   = data_o;
    valid_n  = 1'b0;
    busy_n   = busy_o;
    unique case (state)
      IDLE: begin
        sel_n = '0;
        if (start) begin
          state_n = SCAN;
          wcnt_n  = '0;
          busy_n  = 1'b1;
        end
      end
      SCAN: begin
        if (wcnt < SETTLE_C) begin
          wcnt_n = wcnt + 4'd1;
        end else begin
          shadow_n[sel_o] = y_i;
          if (sel_o != LAST) begin
            sel_n  = sel_o + SEL_W'(1);
            wcnt_n = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        // shadow already holds the last channel's bit here
        data_n  = shadow;
        valid_n = 1'b1;
        sel_n   = '0;
        wcnt_n  = '0;
        if (start) begin
          state_n = SCAN;
          busy_n  = 1'b1;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: scanner plus mux, SETTLE=1 and SETTLE=0 instances.
// Inputs change and outputs are sampled on the falling edge.
module tb_mux_scan_ctrl;
  import mux_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start0;
  logic [7:0] mux_in;
  logic       y1, y0;
  logic [2:0] sel1, sel0;
  logic [7:0] data1, data0;
  logic       valid1, valid0;
  logic       busy1, busy0;

  int checks = 0;
  int errors = 0;
  int vcnt;
  logic [2:0] exp_sel;
  bit found;

  always #5 clk = ~clk;

  mux8to1 u_mux1 (.in(mux_in), .sel(sel1), .y(y1));
  mux8to1 u_mux0 (.in(mux_in), .sel(sel0), .y(y0));

  mux_scan_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_i(y1),
    .sel_o(sel1), .data_o(data1), .valid_o(valid1), .busy_o(busy1)
  );

  mux_scan_ctrl #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .y_i(y0),
    .sel_o(sel0), .data_o(data0), .valid_o(valid0), .busy_o(busy0)
  );

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // waits (bounded) until dut1 select shows s, sampled on falling edge
  task automatic wait_sel1(input logic [2:0] s);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (sel1 == s) found = 1'b1;
    end
    check("wait_sel1_timeout", {7'd0, found}, 8'd1);
  endtask

  // waits (bounded) for a dut1 valid pulse
  task automatic wait_valid1();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (valid1) found = 1'b1;
    end
    check("wait_valid1_timeout", {7'd0, found}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start0 = 1'b0; mux_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // idle after reset
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("idle_sel", {5'd0, sel1}, 8'h00);
      check("idle_data", data1, 8'h00);
      check("idle_valid", {7'd0, valid1}, 8'h00);
      check("idle_busy", {7'd0, busy1}, 8'h00);
    end

    // single scan, SETTLE=1
    mux_in = 8'b1000_1100;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("s1_busy_T", {7'd0, busy1}, 8'h01);
    check("s1_sel_T", {5'd0, sel1}, 8'h00);
    vcnt = 0;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      exp_sel = (n >= 17) ? 3'd0 : ((n / 2 > 7) ? 3'd7 : 3'(n / 2));
      check("s1_sel", {5'd0, sel1}, {5'd0, exp_sel});
      check("s1_valid", {7'd0, valid1}, {7'd0, n == 17});
      if (valid1) vcnt++;
      if (n == 17) check("s1_data", data1, 8'h8C);
    end
    check("s1_pulses", 8'(vcnt), 8'd1);
    check("s1_busy_after", {7'd0, busy1}, 8'h00);
    check("s1_data_hold", data1, 8'h8C);

    // single scan, SETTLE=0
    mux_in = 8'hA5;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      check("s0_valid", {7'd0, valid0}, {7'd0, n == 9});
      if (n == 9) check("s0_data", data0, 8'hA5);
      if (n == 10) check("s0_busy", {7'd0, busy0}, 8'h00);
    end

    // back-to-back with start held high
    mux_in = 8'h0F;
    start1 = 1'b1;
    @(negedge clk);
    vcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      check("b2b_valid", {7'd0, valid1},
            {7'd0, (n == 17) || (n == 34)});
      if (valid1) vcnt++;
      if (n == 17) begin
        check("b2b_data0", data1, 8'h0F);
        check("b2b_busy", {7'd0, busy1}, 8'h01);
        mux_in = 8'hF0;
      end
      if (n == 34) check("b2b_data1", data1, 8'hF0);
    end
    check("b2b_pulses", 8'(vcnt), 8'd2);
    start1 = 1'b0;
    wait_valid1();
    check("b2b_data2", data1, 8'hF0);
    @(negedge clk);
    check("b2b_idle", {7'd0, busy1}, 8'h00);

    // reset mid-scan after a completed 3C scan
    mux_in = 8'h3C;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_valid1();
    check("r_data_pre", data1, 8'h3C);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_sel1(3'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("r_sel", {5'd0, sel1}, 8'h00);
    check("r_busy", {7'd0, busy1}, 8'h00);
    check("r_data", data1, 8'h00);
    vcnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (valid1) vcnt++;
    end
    check("r_no_pulse", 8'(vcnt), 8'd0);

    // input switched after channel 3 has been sampled
    mux_in = 8'h00;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_sel1(3'd4);
    mux_in = 8'hFF;
    wait_valid1();
    check("mid_data", data1, 8'hF0);

    // start during busy is ignored: exactly one pulse
    mux_in = 8'h55;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valid1) vcnt++;
    end
    check("ign_pulses", 8'(vcnt), 8'd1);
    check("ign_data", data1, 8'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
